// File: rtl/inst_bundle_queue.sv
// rtl/inst_bundle_queue.sv - multi-lane decoded-bundle FIFO between decode and issue
// Optional producer stall counter is built only when IBQ_STALL_CNT_EN is defined.
module inst_bundle_queue #(
   parameter int LANES    = 2,
   parameter int DEPTH    = 8,
   parameter int BUNDLE_W = 217
) (
   input  logic                      clk,
   input  logic                      rstn,
   input  logic                      flush,
   input  logic [LANES-1:0]          i_valid,
   input  logic [LANES*BUNDLE_W-1:0] i_bundle,
   output logic                      o_in_ready,
   output logic [LANES-1:0]          o_valid,
   output logic [LANES*BUNDLE_W-1:0] o_bundle,
   input  logic [LANES-1:0]          i_pop,
   output logic [$clog2(DEPTH):0]    o_count,
   output logic [31:0]               o_stall_cnt
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [BUNDLE_W-1:0] mem_q [DEPTH];
   logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [CW-1:0]       push_n, pop_n;
   logic [LANES-1:0]    pop_req;
   logic                push_run, pop_run;

   // Ready looks only at registered occupancy, never at same-cycle pops.
   assign o_in_ready = (cnt_q <= CW'(DEPTH - LANES));
   assign o_count    = cnt_q;

   always_comb begin
      o_valid  = '0;
      o_bundle = '0;
      for (int k = 0; k < LANES; k++) begin
         o_valid[k]                       = (cnt_q > CW'(k));
         o_bundle[k*BUNDLE_W +: BUNDLE_W] = mem_q[rd_ptr_q + PW'(k)];
      end
   end

   // Only the leading-ones run of each request vector is honoured.
   always_comb begin
      push_n   = '0;
      pop_n    = '0;
      push_run = o_in_ready;
      pop_run  = 1'b1;
      pop_req  = i_pop & o_valid;
      for (int k = 0; k < LANES; k++) begin
         push_run = push_run & i_valid[k];
         pop_run  = pop_run & pop_req[k];
         if (push_run) push_n = push_n + CW'(1);
         if (pop_run)  pop_n  = pop_n + CW'(1);
      end
   end

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      cnt_d    = cnt_q;
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         cnt_d    = '0;
      end else begin
         wr_ptr_d = wr_ptr_q + push_n[PW-1:0];
         rd_ptr_d = rd_ptr_q + pop_n[PW-1:0];
         cnt_d    = cnt_q + push_n - pop_n;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!flush) begin
         for (int k = 0; k < LANES; k++) begin
            if (CW'(k) < push_n)
               mem_q[wr_ptr_q + PW'(k)] <= i_bundle[k*BUNDLE_W +: BUNDLE_W];
         end
      end
   end

`ifdef IBQ_STALL_CNT_EN
   logic [31:0] stall_q, stall_d;

   always_comb begin
      stall_d = stall_q;
      if (i_valid[0] && !o_in_ready && !flush && (stall_q != 32'hFFFF_FFFF))
         stall_d = stall_q + 32'd1;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) stall_q <= '0;
      else       stall_q <= stall_d;
   end

   assign o_stall_cnt = stall_q;
`else
   assign o_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_inst_bundle_queue.sv
// tb/tb_inst_bundle_queue.sv - scoreboard bench for inst_bundle_queue
module tb_inst_bundle_queue;
   localparam int LANES = 2;
   localparam int DEPTH = 8;
   localparam int BW    = 217;

   logic                clk      = 1'b0;
   logic                rstn     = 1'b0;
   logic                flush    = 1'b0;
   logic [LANES-1:0]    i_valid  = '0;
   logic [LANES-1:0]    i_pop    = '0;
   logic [LANES*BW-1:0] i_bundle = '0;
   logic                o_in_ready;
   logic [LANES-1:0]    o_valid;
   logic [LANES*BW-1:0] o_bundle;
   logic [3:0]          o_count;
   logic [31:0]         o_stall_cnt;

   int checks   = 0;
   int failures = 0;
   logic [BW-1:0] exp_q[$];

   inst_bundle_queue #(.LANES(LANES), .DEPTH(DEPTH), .BUNDLE_W(BW)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .flush      (flush),
      .i_valid    (i_valid),
      .i_bundle   (i_bundle),
      .o_in_ready (o_in_ready),
      .o_valid    (o_valid),
      .o_bundle   (o_bundle),
      .i_pop      (i_pop),
      .o_count    (o_count),
      .o_stall_cnt(o_stall_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [BW-1:0] mk(input logic [31:0] pc);
      return {~pc, 153'(pc * 32'd3), pc};
   endfunction

   function automatic void chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endfunction

   function automatic int lead(input logic [LANES-1:0] v, input int lim);
      int n;
      n = 0;
      for (int k = 0; k < LANES; k++)
         if (v[k] && (k < lim) && (n == k)) n++;
      return n;
   endfunction

   // Monitor: compare presented lanes against the scoreboard, then apply this cycle's traffic.
   always @(negedge clk) begin
      int sz;
      int pn;
      int un;
      if (rstn) begin
         sz = exp_q.size();
         chk("mon_count", 256'(o_count), 256'(sz));
         chk("mon_ready", 256'(o_in_ready), 256'(sz <= DEPTH - LANES));
         for (int k = 0; k < LANES; k++) begin
            chk("mon_valid", 256'(o_valid[k]), 256'(sz > k));
            if (k < sz) chk("mon_bundle", 256'(o_bundle[k*BW +: BW]), 256'(exp_q[k]));
         end
         if (flush) begin
            exp_q.delete();
         end else begin
            pn = lead(i_pop, sz);
            un = (sz <= DEPTH - LANES) ? lead(i_valid, LANES) : 0;
            repeat (pn) void'(exp_q.pop_front());
            for (int k = 0; k < un; k++) exp_q.push_back(i_bundle[k*BW +: BW]);
         end
      end
   end

   task automatic tick(input logic [1:0] v, input logic [31:0] pc0, input logic [31:0] pc1,
                       input logic [1:0] pop, input logic fl);
      i_valid  = v;
      i_bundle = {mk(pc1), mk(pc0)};
      i_pop    = pop;
      flush    = fl;
      @(posedge clk);
      #1;
      i_valid = '0;
      i_pop   = '0;
      flush   = 1'b0;
   endtask

   initial begin
      logic [31:0] exp_stall;
`ifdef IBQ_STALL_CNT_EN
      exp_stall = 32'd5;
`else
      exp_stall = 32'd0;
`endif
      repeat (3) @(posedge clk);
      #1 rstn = 1'b1;
      chk("rst_count", 256'(o_count), 256'(0));
      chk("rst_valid", 256'(o_valid), 256'(0));
      chk("rst_ready", 256'(o_in_ready), 256'(1));
      chk("rst_stall", 256'(o_stall_cnt), 256'(0));

      tick(2'b11, 32'h1c00_0000, 32'h1c00_0004, 2'b00, 1'b0);
      chk("push_count", 256'(o_count), 256'(2));
      chk("push_valid", 256'(o_valid), 256'(2'b11));
      chk("push_pc0", 256'(o_bundle[31:0]), 256'(32'h1c00_0000));
      chk("push_pc1", 256'(o_bundle[BW+31:BW]), 256'(32'h1c00_0004));
      tick(2'b00, 32'h0, 32'h0, 2'b11, 1'b0);
      chk("drain_count", 256'(o_count), 256'(0));

      for (int i = 0; i < 4; i++)
         tick(2'b11, 32'h100 + 32'(8*i), 32'h104 + 32'(8*i), 2'b00, 1'b0);
      chk("full_count", 256'(o_count), 256'(8));
      chk("full_ready", 256'(o_in_ready), 256'(0));

      repeat (5) tick(2'b01, 32'h200, 32'h0, 2'b00, 1'b0);
      chk("stall_cnt", 256'(o_stall_cnt), 256'(exp_stall));
      chk("stall_count", 256'(o_count), 256'(8));

      tick(2'b11, 32'h300, 32'h304, 2'b11, 1'b0);
      chk("full_pop_refused", 256'(o_count), 256'(6));
      tick(2'b11, 32'h300, 32'h304, 2'b00, 1'b0);
      chk("held_push_accept", 256'(o_count), 256'(8));

      tick(2'b00, 32'h0, 32'h0, 2'b11, 1'b0);
      tick(2'b00, 32'h0, 32'h0, 2'b01, 1'b0);
      chk("five_count", 256'(o_count), 256'(5));
      tick(2'b11, 32'h400, 32'h404, 2'b11, 1'b1);
      chk("flush_count", 256'(o_count), 256'(0));
      chk("flush_valid", 256'(o_valid), 256'(0));
      chk("flush_ready", 256'(o_in_ready), 256'(1));
      tick(2'b00, 32'h0, 32'h0, 2'b11, 1'b0);
      chk("empty_pop", 256'(o_count), 256'(0));

      tick(2'b11, 32'h500, 32'h504, 2'b00, 1'b0);
      tick(2'b00, 32'h0, 32'h0, 2'b10, 1'b0);
      chk("pop_lane1_only", 256'(o_count), 256'(2));
      tick(2'b00, 32'h0, 32'h0, 2'b01, 1'b0);
      chk("pop_lane0_count", 256'(o_count), 256'(1));
      chk("pop_lane0_pc", 256'(o_bundle[31:0]), 256'(32'h504));
      tick(2'b00, 32'h0, 32'h0, 2'b01, 1'b0);

      tick(2'b11, 32'h600, 32'h604, 2'b00, 1'b0);
      tick(2'b11, 32'h608, 32'h60c, 2'b00, 1'b0);
      tick(2'b01, 32'h610, 32'h0, 2'b00, 1'b0);
      tick(2'b00, 32'h0, 32'h0, 2'b11, 1'b0);
      tick(2'b00, 32'h0, 32'h0, 2'b11, 1'b0);
      tick(2'b00, 32'h0, 32'h0, 2'b01, 1'b0);
      chk("pre_wrap_count", 256'(o_count), 256'(0));
      tick(2'b11, 32'h700, 32'h704, 2'b00, 1'b0);
      chk("wrap_count", 256'(o_count), 256'(2));
      chk("wrap_pc0", 256'(o_bundle[31:0]), 256'(32'h700));
      chk("wrap_pc1", 256'(o_bundle[BW+31:BW]), 256'(32'h704));
      tick(2'b11, 32'h708, 32'h70c, 2'b01, 1'b0);
      chk("pushpop_count", 256'(o_count), 256'(3));
      chk("pushpop_pc0", 256'(o_bundle[31:0]), 256'(32'h704));
      chk("pushpop_pc1", 256'(o_bundle[BW+31:BW]), 256'(32'h708));
      tick(2'b10, 32'h800, 32'h804, 2'b00, 1'b0);
      chk("nonprefix_push", 256'(o_count), 256'(3));

      repeat (2) @(posedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/inst_bundle_queue.md
Name: inst_bundle_queue

Overview:
- Parametrised multi-lane FIFO of decoded instruction bundles (flattened PC_set payload) between the decode and issue stages.
- Accepts up to LANES bundles per cycle from decode and presents the oldest LANES entries to issue in order.
- Issue may consume a prefix of the presented lanes each cycle.
- Supports pipeline flush on branch mispredict or exception.

Parameters:
- LANES, 2, bundles pushed/presented per cycle; legal values 1..4.
- DEPTH, 8, entries; power of 2, must be >= 2*LANES.
- BUNDLE_W, 217, bits per bundle; 217 is the packed width of PC_set.

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- flush  in  1  discard all entries; highest priority.
- i_valid  in  LANES  push request per lane; must be a prefix (lane k set implies lanes 0..k-1 set).
- i_bundle  in  LANES*BUNDLE_W  lane k occupies bits [k*BUNDLE_W +: BUNDLE_W].
- o_in_ready  out  1  high when free entries >= LANES.
- o_valid  out  LANES  lane k holds the k-th oldest entry.
- o_bundle  out  LANES*BUNDLE_W  presented bundles, same lane packing as i_bundle.
- i_pop  in  LANES  consume request per lane.
- o_count  out  $clog2(DEPTH)+1  current occupancy.
- o_stall_cnt  out  32  producer stall cycles; see Optional Feature.

Behaviour:
- Storage: DEPTH x BUNDLE_W array, read pointer rd_ptr, write pointer wr_ptr, occupancy cnt. Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- Reset: rstn low asynchronously clears rd_ptr, wr_ptr and cnt. Resulting outputs: o_valid=0, o_count=0, o_in_ready=1, o_stall_cnt=0. o_bundle is don't-care while the matching o_valid is 0. Storage array is not reset.
- push_n: number of set bits in i_valid when o_in_ready=1, else 0.
  - Acceptance is all-or-nothing per cycle.
  - The producer holds i_valid/i_bundle until o_in_ready is seen.
  - A non-prefix i_valid pattern is a protocol error; only the leading-ones prefix is counted.
- o_in_ready: depends only on the registered cnt (DEPTH-cnt >= LANES). It does not depend on pops in the same cycle, so there is no combinational path from i_pop to o_in_ready.
- o_valid[k] = (cnt > k). o_bundle lane k = mem[(rd_ptr+k) mod DEPTH]. Pure combinational read of registered state.
- pop_n: number of leading ones of (i_pop & o_valid). Popping lane 1 without lane 0 pops nothing. Popping an invalid lane is ignored.
- Update each clock when flush=0:
  - Write push lanes 0..push_n-1 to mem[wr_ptr+k].
  - wr_ptr += push_n; rd_ptr += pop_n; cnt += push_n - pop_n.
- Latency: a bundle pushed in cycle N is visible on o_valid in cycle N+1. No fall-through path from input to output.
- Simultaneous push and pop:
  - Both occur in the same cycle; cnt stays within 0..DEPTH.
  - Pop from a full queue while a push is pending: the push is still refused that cycle, because o_in_ready was computed from the full cnt.
- Flush (synchronous):
  - Next cycle rd_ptr=wr_ptr=0 and cnt=0.
  - Same-cycle push and pop are discarded.
  - o_valid=0 from the next cycle; o_in_ready=1.
- Wrap-around: entries straddling index DEPTH-1 -> 0 are presented in correct order on consecutive lanes.
- Empty: o_valid=0; i_pop is ignored. Full: o_in_ready=0; i_valid is ignored.

Optional Feature:
- Macro IBQ_STALL_CNT_EN.
- Defined:
  - o_stall_cnt increments by 1 each cycle with i_valid[0]=1, o_in_ready=0 and flush=0.
  - Saturates at 32'hFFFF_FFFF.
  - Cleared by reset only; flush does not clear it.
- Undefined: the counter register is not built; o_stall_cnt is tied to 0.

Test Plan:
- Reset then push lanes 0,1 with PC 0x1c000000/0x1c000004 -> next cycle o_valid=2'b11, o_count=2, o_bundle PCs match in order.
- Fill with 8 entries (4 dual pushes) -> o_in_ready=0, o_count=8. Pop 2'b11 while i_valid=2'b11 -> push refused, o_count=6; the following cycle the push is accepted, o_count=8.
- Push 2, pop 2'b10 (lane 1 only) -> nothing popped, o_count stays 2. Pop 2'b01 -> o_count=1, lane 0 now shows the second PC.
- Cycle 10 pushes/pops through 8 entries so the pointers wrap (rd_ptr=7, cnt=2) -> lane 0=mem[7], lane 1=mem[0], order preserved.
- With 5 entries: assert flush together with i_valid=2'b11 and i_pop=2'b11 -> next cycle o_count=0, o_valid=0, o_in_ready=1, no entry written.
- With IBQ_STALL_CNT_EN: hold i_valid=2'b01 on a full queue for 5 cycles -> o_stall_cnt=5. Macro undefined -> o_stall_cnt=0.
